// File: rtl/cpu_data_mem_ctrl.sv
// CPU data-port memory controller: on-chip word array, byte-enable writes, programmable wait states.
// Optional macro CPU_DATA_MEM_ALIGN_CHECK_EN adds an AccessError output and rejects misaligned requests.
`timescale 1ns/1ps

module cpu_data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [ADDR_W-1:0]   AddressBus,
    input  logic [DATA_W-1:0]   DataWriteBus,
    input  logic [DATA_W/8-1:0] ByteEnable,
    input  logic                ReadAssert,
    input  logic                WriteAssert,
    output logic [DATA_W-1:0]   DataReadBus,
    output logic                ReadOK,
    output logic                WriteOK,
    output logic                Busy
`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
    ,output logic               AccessError
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic              op_write_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic              misaligned;
    logic              do_access;

    assign word_idx  = addr_q >> OFF_W;
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign in_range  = word_idx < ADDR_W'(DEPTH);
    assign do_access = (state == WAIT) && (cnt == 8'd0);

`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
    assign misaligned  = |(addr_q & ADDR_W'(NB - 1));
    assign AccessError = (state == DONE) && misaligned;
`else
    assign misaligned  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            op_write_q  <= 1'b0;
            DataReadBus <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReadAssert || WriteAssert) begin
                        addr_q     <= AddressBus;
                        wdata_q    <= DataWriteBus;
                        be_q       <= ByteEnable;
                        op_write_q <= WriteAssert;
                        cnt        <= 8'(WAIT_STATES);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        if (!op_write_q && !misaligned)
                            DataReadBus <= in_range ? mem[mem_idx] : '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; an async reset forces IDLE, which blocks any pending write.
    always_ff @(posedge Clock) begin
        if (do_access && op_write_q && in_range && !misaligned) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b])
                    mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign ReadOK  = (state == DONE) && !op_write_q;
    assign WriteOK = (state == DONE) && op_write_q;
    assign Busy    = (state == WAIT) || (state == DONE);

endmodule

// File: tb/tb_cpu_data_mem_ctrl.sv
// Self-checking bench for cpu_data_mem_ctrl: a zero-wait instance and a three-wait instance
// checked against a word-array reference model driven by directed and random requests.
`timescale 1ns/1ps

module tb_cpu_data_mem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0_n, rst3_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          rd0, wr0, rd3, wr3;
    logic [DW-1:0] rdata0, rdata3;
    logic          rok0, wok0, busy0, rok3, wok3, busy3;
    logic          err0, err3;

    cpu_data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clock(clk), .nReset(rst0_n), .AddressBus(addr), .DataWriteBus(wdata),
        .ByteEnable(be), .ReadAssert(rd0), .WriteAssert(wr0), .DataReadBus(rdata0),
        .ReadOK(rok0), .WriteOK(wok0), .Busy(busy0)
`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
        , .AccessError(err0)
`endif
    );

    cpu_data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .Clock(clk), .nReset(rst3_n), .AddressBus(addr), .DataWriteBus(wdata),
        .ByteEnable(be), .ReadAssert(rd3), .WriteAssert(wr3), .DataReadBus(rdata3),
        .ReadOK(rok3), .WriteOK(wok3), .Busy(busy3)
`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
        , .AccessError(err3)
`endif
    );

`ifndef CPU_DATA_MEM_ALIGN_CHECK_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    logic          sel;
    wire           s_rok   = sel ? rok3   : rok0;
    wire           s_wok   = sel ? wok3   : wok0;
    wire           s_busy  = sel ? busy3  : busy0;
    wire           s_err   = sel ? err3   : err0;
    wire  [DW-1:0] s_rdata = sel ? rdata3 : rdata0;

    int tests = 0;
    int fails = 0;

    // Reference model: one word array and one read-data latch per instance.
    logic [31:0] mm  [2][DEPTH];
    logic [31:0] mrd [2];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input int w, input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output logic er, output logic ew, output logic eerr);
        int          idx;
        logic        mis;
        logic [31:0] mask;
        idx  = int'(a / 4);
        mis  = 1'b0;
`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
        mis  = (a % 4) != 0;
`endif
        ew   = wr;
        er   = rd && !wr;
        eerr = mis;
        if (!mis) begin
            if (wr) begin
                if (idx < DEPTH) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) begin
                            mask = 32'hFF << (8 * k);
                            mm[w][idx] = (mm[w][idx] & ~mask) | (d & mask);
                        end
                    end
                end
            end else if (rd) begin
                mrd[w] = (idx < DEPTH) ? mm[w][idx] : 32'h0;
            end
        end
    endtask

    // Entered and left just after a rising edge with the selected instance idle.
    task automatic do_op(input int w, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input string tag);
        logic        er, ew, eerr, got_r, got_w, g_err;
        logic [31:0] rdv;
        int          lat, busy_n, ws;
        ws = (w != 0) ? 3 : 0;
        model_op(w, rd, wr, a, d, b, er, ew, eerr);
        sel = (w != 0);
        addr = a; wdata = d; be = b;
        if (w != 0) begin rd3 = rd; wr3 = wr; end else begin rd0 = rd; wr0 = wr; end
        lat = -1; busy_n = 0; got_r = 1'b0; got_w = 1'b0; g_err = 1'b0; rdv = '0;
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        addr = $urandom; wdata = $urandom; be = 4'($urandom);
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (s_busy) busy_n++;
            if (s_rok || s_wok) begin
                lat = j; got_r = s_rok; got_w = s_wok; rdv = s_rdata; g_err = s_err;
                break;
            end
        end
        @(posedge clk); #1;
        check({tag, ".latency"}, lat, ws + 1);
        check({tag, ".busy_cycles"}, busy_n, ws + 2);
        check({tag, ".write_ok"}, got_w, ew);
        check({tag, ".read_ok"}, got_r, er);
        check({tag, ".read_data"}, rdv, mrd[w]);
        check({tag, ".idle_after"}, s_busy, 1'b0);
`ifdef CPU_DATA_MEM_ALIGN_CHECK_EN
        check({tag, ".access_error"}, g_err, eerr);
`endif
        last_rdata = rdv;
    endtask

    initial begin
        int ok_cnt;
        logic [1:0] kind;
        sel = 1'b0; rst0_n = 1'b0; rst3_n = 1'b0;
        addr = '0; wdata = '0; be = '0;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        mrd[0] = '0; mrd[1] = '0; last_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.rdata0", rdata0, 32'h0);
        check("reset.rok0", rok0, 1'b0);
        check("reset.wok0", wok0, 1'b0);
        check("reset.busy0", busy0, 1'b0);
        check("reset.busy3", busy3, 1'b0);
        @(negedge clk);
        rst0_n = 1'b1; rst3_n = 1'b1;
        ok_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rok0 || wok0 || rok3 || wok3 || busy0 || busy3) ok_cnt++;
        end
        check("idle.no_activity", ok_cnt, 0);
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) do_op(0, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "init0");
        for (int i = 0; i < DEPTH; i++) do_op(1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "init3");

        do_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "full_write");
        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "full_read");
        check("full_read.value", last_rdata, 32'hDEADBEEF);
        do_op(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'h6, "partial_write");
        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "partial_read");
        check("partial_read.value", last_rdata, 32'hDE2233EF);
        do_op(0, 1'b0, 1'b1, 32'h18, 32'h0BADF00D, 4'h0, "be_zero_write");

        do_op(0, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF, "both_strobes");
        do_op(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "both_readback");
        check("both_readback.value", last_rdata, 32'h12345678);

        do_op(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, "oor_write");
        do_op(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, "oor_read");
        check("oor_read.value", last_rdata, 32'h0);

        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "pre_offset_read");
        do_op(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, "offset_read");
        check("offset_read.value", last_rdata, 32'hDE2233EF);

        // Asynchronous reset while a read completion is on the bus.
        sel = 1'b0; addr = 32'h10; rd0 = 1'b1;
        @(posedge clk); #1 rd0 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("async.rok_before", rok0, 1'b1);
        #2 rst0_n = 1'b0;
        #1;
        check("async.rok", rok0, 1'b0);
        check("async.busy", busy0, 1'b0);
        check("async.rdata", rdata0, 32'h0);
        mrd[0] = '0;
        @(negedge clk) rst0_n = 1'b1;
        @(posedge clk); #1;

        do_op(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, "ws3_write");
        do_op(1, 1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, "ws3_seed");

        // Reset during the second WAIT cycle of a write must abort it.
        sel = 1'b1; addr = 32'h24; wdata = 32'h55; be = 4'hF; wr3 = 1'b1;
        @(posedge clk); #1 wr3 = 1'b0;
        @(posedge clk); #3 rst3_n = 1'b0;
        #1 check("abort.busy", busy3, 1'b0);
        @(negedge clk) rst3_n = 1'b1;
        ok_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (wok3 || rok3) ok_cnt++;
        end
        check("abort.no_ok", ok_cnt, 0);
        mrd[1] = '0;
        @(posedge clk); #1;
        do_op(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, "abort_readback");
        check("abort_readback.value", last_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 200; i++) begin
            kind = 2'($urandom_range(0, 2));
            do_op(0, kind != 2'd1, kind != 2'd0, $urandom_range(0, DEPTH * 4 + 15),
                  $urandom, 4'($urandom), "rand0");
        end
        for (int i = 0; i < 30; i++) begin
            kind = 2'($urandom_range(0, 2));
            do_op(1, kind != 2'd1, kind != 2'd0, $urandom_range(0, DEPTH * 4 + 7),
                  $urandom, 4'($urandom), "rand3");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
